dmt_pixel_fetch: RTL and testbench
==================================

# dmt_pixel_fetch

Downstream stage of `dmt_timing_generate` in the HDMI output path. Consumes the DMT `vsycn`/`hsync`/`de` strobes and pops RGB565 pixels from the frame-buffer read FIFO on each active pixel. Emits RGB888 with sync/`de` delayed to align with the data. Detects FIFO underflow and short or long lines, and resynchronises on the next frame. Issues a `frame_start` pulse so the frame-buffer reader rewinds its address.

## Interface
- `H_ACTIVE`, 1280: active pixels per line.
- `V_ACTIVE`, 720: active lines per frame.
- `ERR_W`, 16: width of the saturating error counters.

Ports:
- `pixe_clk` in 1: pixel clock; the only clock.
- `rest_n` in 1: reset, synchronous, active-low.
- `vsycn_i`, `hsync_i`, `de_i` in 1 each: timing from `dmt_timing_generate`; active-high polarity.
- `fifo_empty` in 1: read FIFO empty.
- `fifo_rd_en` out 1: pop request; data is valid the following cycle.
- `fifo_rdata` in 16: RGB565, {R[4:0], G[5:0], B[4:0]}.
- `frame_start` out 1: one-cycle pulse on each rising edge of `vsycn_i`.
- `vsycn_o`, `hsync_o`, `de_o` out 1 each: timing delayed 2 cycles.
- `rgb_o` out 24: RGB888 {R,G,B}.
- `underflow_cnt` out `ERR_W`: saturating count of underflow events.
- `line_err_cnt` out `ERR_W`: saturating count of lines whose `de` run ≠ `H_ACTIVE`.
- `locked` out 1: high in ACTIVE state.

## Operation
- State machine:
  - IDLE (after reset): no reads.
  - On `vsycn_i` rise → ACTIVE.
  - In ACTIVE, `de_i`=1 with `fifo_empty`=1 → RESYNC.
  - RESYNC: no reads until the next `vsycn_i` rise, then → ACTIVE.
- `fifo_rd_en` = `de_i` & `!fifo_empty` & (state==ACTIVE), combinational.
- Underflow:
  - Counted once per entry to RESYNC, not per pixel.
  - The pixel that triggered RESYNC, and all pixels until ACTIVE, output `rgb_o`=0.
- `frame_start` is a registered pulse, 1 cycle after the `vsycn_i` rise, in every state including IDLE.
- Colour expansion uses MSB replication: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
- Pixel counter x:
  - Increments on `de_i`; cleared when `de_i`=0.
  - On the `de_i` falling edge, x≠`H_ACTIVE` → `line_err_cnt`++.
  - Counter width is sized for `H_ACTIVE`; x saturates at `H_ACTIVE`+1.
- Line counter y:
  - Increments on the `de_i` falling edge; cleared on `vsycn_i` rise.
  - y has no error reporting; it exists for the bench.
- Counters saturate at all-ones and never wrap.
- Simultaneous events:
  - `vsycn_i` rise with `de_i`=1: vsync takes precedence (→ ACTIVE), and the read is still gated by `fifo_empty`.
  - Underflow and line error in the same cycle: both counters increment.
- `rest_n`=0 mid-frame:
  - All outputs and counters clear on the next edge; state → IDLE.
  - No reads until the next `vsycn_i` rise, so pixels of the partial frame are never popped.

## Timing
- Reset values:
  - `fifo_rd_en`=0 (state IDLE); `frame_start`=0.
  - `vsycn_o`=`hsync_o`=`de_o`=0; `rgb_o`=0.
  - Both counters 0; `locked`=0.
- Latency: `de_i` at cycle n → `fifo_rd_en` at n → `fifo_rdata` at n+1 → `rgb_o`/`de_o` registered at n+2. Syncs use the same 2-stage delay.
- `rgb_o` is 0 whenever `de_o`=0.
- Throughput: one pixel per clock, with no back-pressure toward the timing generator.
- State transitions take effect on the clock edge following the triggering input.

## Structure
- Shared package `dmt_pkg`:
  - `rgb565_t`/`rgb888_t` packed structs.
  - The fetch-state enum {IDLE, ACTIVE, RESYNC}.
  - Default `H_ACTIVE`/`V_ACTIVE` constants, shared with `dmt_timing_generate`.
- One natural sub-module, `dmt_sync_delay`: a parameterised N-stage shift register for {vsync, hsync, de}, instantiated with N=2.

## Test plan
- Bench uses `H_ACTIVE`=8, `V_ACTIVE`=4.
- Reset then first frame, with FIFO preloaded with 0xF800, 0x07E0, 0x001F, …:
  - `frame_start` pulses once.
  - First `de_o` pixel is `rgb_o`=0xFF0000, then 0x00FF00, then 0x0000FF.
  - `de_o` lags `de_i` by exactly 2 cycles.
- Reset with `de_i` active mid-frame: no `fifo_rd_en` until the next `vsycn_i` rise; `locked` goes 1 one cycle after that rise.
- FIFO empty at pixel 3 of line 2:
  - `underflow_cnt`=1; `locked`=0; remaining pixels are `rgb_o`=0.
  - No `fifo_rd_en` until the next frame, then `locked`=1 again.
- Line error: timing source drives a 7-pixel `de` run → `line_err_cnt`=1. A 9-pixel run → `line_err_cnt`=2. `underflow_cnt` is unchanged for both.
- Saturation: with `ERR_W`=2, force 5 underflow frames → `underflow_cnt` holds at 3.
- `rest_n` deasserted for one cycle during an active line → all outputs 0 on the next edge and counters cleared.

Source files
------------

// File: rtl/dmt_pkg.sv
// Shared types and defaults for the DMT video output path.
//   rgb565_t / rgb888_t : pixel payloads as read from the frame buffer / sent to HDMI
//   fetch_state_e       : pixel-fetch state machine encoding
//   H_ACTIVE_DEF / V_ACTIVE_DEF : default active area, shared with dmt_timing_generate
package dmt_pkg;

    localparam int unsigned H_ACTIVE_DEF = 1280;
    localparam int unsigned V_ACTIVE_DEF = 720;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        RESYNC
    } fetch_state_e;

    // MSB replication keeps full-scale inputs at full scale (0x1F -> 0xFF)
    function automatic rgb888_t rgb565_to_888(input rgb565_t p);
        rgb888_t q;
        q.r = {p.r, p.r[4:2]};
        q.g = {p.g, p.g[5:4]};
        q.b = {p.b, p.b[4:2]};
        return q;
    endfunction

endpackage

// File: rtl/dmt_sync_delay.sv
// N-stage shift register for the {vsync, hsync, de} strobes.
//   clk, rst_n : clock, synchronous active-low reset
//   sync_in    : {vsync, hsync, de} in
//   sync_out   : sync_in delayed by N cycles
module dmt_sync_delay #(
    parameter int unsigned N = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sync_in,
    output logic [2:0] sync_out
);

    logic [2:0] stage [N];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N); i++) stage[i] <= '0;
        end else begin
            stage[0] <= sync_in;
            for (int i = 1; i < int'(N); i++) stage[i] <= stage[i-1];
        end
    end

    assign sync_out = stage[N-1];

endmodule

// File: rtl/dmt_pixel_fetch.sv
// Pops RGB565 pixels from the frame-buffer FIFO on each active pixel and emits
// RGB888 with the DMT strobes delayed to line up with the data. Tracks FIFO
// underflow and bad line lengths, and resynchronises on the next frame.
//   pixe_clk, rest_n          : pixel clock, synchronous active-low reset
//   vsycn_i, hsync_i, de_i    : timing strobes from dmt_timing_generate
//   fifo_empty, fifo_rd_en    : FIFO status / pop (data valid next cycle)
//   fifo_rdata                : RGB565 pixel
//   frame_start               : one-cycle pulse after each vsync rise
//   vsycn_o, hsync_o, de_o    : strobes delayed 2 cycles
//   rgb_o                     : RGB888, zero outside fetched pixels
//   underflow_cnt, line_err_cnt : saturating error counters
//   locked                    : fetch state is ACTIVE
//   line_cnt                  : lines seen since the last vsync rise (debug)
module dmt_pixel_fetch
    import dmt_pkg::*;
#(
    parameter  int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter  int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter  int unsigned ERR_W    = 16,
    localparam int unsigned Y_W      = $clog2(V_ACTIVE + 2)
) (
    input  logic             pixe_clk,
    input  logic             rest_n,
    input  logic             vsycn_i,
    input  logic             hsync_i,
    input  logic             de_i,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [15:0]      fifo_rdata,
    output logic             frame_start,
    output logic             vsycn_o,
    output logic             hsync_o,
    output logic             de_o,
    output logic [23:0]      rgb_o,
    output logic [ERR_W-1:0] underflow_cnt,
    output logic [ERR_W-1:0] line_err_cnt,
    output logic             locked,
    output logic [Y_W-1:0]   line_cnt
);

    // x saturates one past a full line so long lines stay distinguishable
    localparam int unsigned   X_W    = $clog2(H_ACTIVE + 2);
    localparam logic [X_W-1:0] X_LINE = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] X_MAX  = X_W'(H_ACTIVE + 1);

    fetch_state_e   state, state_nxt;
    logic           vs_q, de_q;
    logic           vs_rise_c, de_fall_c, underflow_c, line_err_c;
    logic [X_W-1:0] x;
    logic           valid_d1;
    logic [2:0]     sync_dly;

    assign vs_rise_c  = vsycn_i & ~vs_q;
    assign de_fall_c  = de_q & ~de_i;
    assign line_err_c = de_fall_c & (x != X_LINE);
    assign fifo_rd_en = de_i & ~fifo_empty & (state == ACTIVE);

    // State register
    always_ff @(posedge pixe_clk) begin
        if (!rest_n) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next state; vsync rise wins over an underflow in the same cycle
    always_comb begin
        state_nxt   = state;
        underflow_c = 1'b0;
        case (state)
            IDLE: begin
                if (vs_rise_c) state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (vs_rise_c) begin
                    state_nxt = ACTIVE;
                end else if (de_i && fifo_empty) begin
                    state_nxt   = RESYNC;
                    underflow_c = 1'b1;
                end
            end
            RESYNC: begin
                if (vs_rise_c) state_nxt = ACTIVE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Edge detect, counters and pixel datapath
    always_ff @(posedge pixe_clk) begin
        if (!rest_n) begin
            locked        <= 1'b0;
            vs_q          <= 1'b0;
            de_q          <= 1'b0;
            frame_start   <= 1'b0;
            x             <= '0;
            line_cnt      <= '0;
            underflow_cnt <= '0;
            line_err_cnt  <= '0;
            valid_d1      <= 1'b0;
            rgb_o         <= '0;
        end else begin
            locked      <= (state_nxt == ACTIVE);
            vs_q        <= vsycn_i;
            de_q        <= de_i;
            frame_start <= vs_rise_c;

            if (!de_i)           x <= '0;
            else if (x != X_MAX) x <= x + X_W'(1);

            if (vs_rise_c)
                line_cnt <= '0;
            else if (de_fall_c && (line_cnt != '1))
                line_cnt <= line_cnt + Y_W'(1);

            if (underflow_c && (underflow_cnt != '1))
                underflow_cnt <= underflow_cnt + ERR_W'(1);
            if (line_err_c && (line_err_cnt != '1))
                line_err_cnt <= line_err_cnt + ERR_W'(1);

            // Only popped pixels carry colour; skipped pixels are black
            valid_d1 <= fifo_rd_en;
            rgb_o    <= valid_d1 ? 24'(rgb565_to_888(rgb565_t'(fifo_rdata))) : 24'h0;
        end
    end

    dmt_sync_delay #(.N(2)) u_sync_delay (
        .clk      (pixe_clk),
        .rst_n    (rest_n),
        .sync_in  ({vsycn_i, hsync_i, de_i}),
        .sync_out (sync_dly)
    );

    assign {vsycn_o, hsync_o, de_o} = sync_dly;

endmodule

// File: tb/tb_dmt_pixel_fetch.sv
// Bench for dmt_pixel_fetch: directed frames plus random timing, checked each
// cycle against a behavioural model, with two DUTs (ERR_W=16 and ERR_W=2).
module tb_dmt_pixel_fetch;

    localparam int H = 8;
    localparam int V = 4;
    localparam int Y_W = $clog2(V + 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rest_n = 1'b0, vsycn_i = 1'b0, hsync_i = 1'b0, de_i = 1'b0, fifo_empty = 1'b1;
    logic [15:0] fifo_rdata = '0;

    logic            fifo_rd_en, frame_start, vsycn_o, hsync_o, de_o, locked;
    logic [23:0]     rgb_o;
    logic [15:0]     underflow_cnt, line_err_cnt;
    logic [Y_W-1:0]  line_cnt;

    logic            s_rd_en, s_frame_start, s_vs_o, s_hs_o, s_de_o, s_locked;
    logic [23:0]     s_rgb_o;
    logic [1:0]      s_uf_cnt, s_le_cnt;
    logic [Y_W-1:0]  s_line_cnt;

    dmt_pixel_fetch #(.H_ACTIVE(H), .V_ACTIVE(V), .ERR_W(16)) u_dut (
        .pixe_clk(clk), .rest_n(rest_n), .vsycn_i(vsycn_i), .hsync_i(hsync_i), .de_i(de_i),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata),
        .frame_start(frame_start), .vsycn_o(vsycn_o), .hsync_o(hsync_o), .de_o(de_o),
        .rgb_o(rgb_o), .underflow_cnt(underflow_cnt), .line_err_cnt(line_err_cnt),
        .locked(locked), .line_cnt(line_cnt));

    dmt_pixel_fetch #(.H_ACTIVE(H), .V_ACTIVE(V), .ERR_W(2)) u_sat (
        .pixe_clk(clk), .rest_n(rest_n), .vsycn_i(vsycn_i), .hsync_i(hsync_i), .de_i(de_i),
        .fifo_empty(fifo_empty), .fifo_rd_en(s_rd_en), .fifo_rdata(fifo_rdata),
        .frame_start(s_frame_start), .vsycn_o(s_vs_o), .hsync_o(s_hs_o), .de_o(s_de_o),
        .rgb_o(s_rgb_o), .underflow_cnt(s_uf_cnt), .line_err_cnt(s_le_cnt),
        .locked(s_locked), .line_cnt(s_line_cnt));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // RGB565 -> RGB888 by shifting each field up and refilling low bits from its top bits
    function automatic logic [23:0] expand(input logic [15:0] w);
        int r, g, b;
        r = int'(w[15:11]);
        g = int'(w[10:5]);
        b = int'(w[4:0]);
        return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        vs;
        logic        hs;
        logic        de;
        logic [23:0] rgb;
    } out_t;

    logic [15:0] q[$];
    out_t        pipe0, pipe1;
    bit          m_valid = 0, m_locked = 0, m_prev_vs = 0, m_fs = 0;
    int          m_run = 0, m_uf = 0, m_le = 0, m_y = 0, cyc = 0;
    bit          rd_seen = 0;

    // One clock of the model, evaluated at the active edge with the inputs of the ending cycle
    task automatic model_step();
        bit          vs_rise, rd;
        logic [15:0] w;
        cyc++;
        w = (q.size() > 0) ? q[0] : 16'h0;
        if (rd_seen && q.size() > 0) begin
            void'(q.pop_front());
            fifo_rdata <= w;
        end
        if (!rest_n) begin
            m_valid = 1; m_locked = 0; m_prev_vs = 0; m_fs = 0;
            m_run = 0; m_uf = 0; m_le = 0; m_y = 0;
            pipe0 = '0; pipe1 = '0;
        end else begin
            vs_rise = vsycn_i && !m_prev_vs;
            rd      = de_i && !fifo_empty && m_locked;
            pipe1   = pipe0;
            pipe0   = '{vs: vsycn_i, hs: hsync_i, de: de_i, rgb: rd ? expand(w) : 24'h0};
            m_fs    = vs_rise;
            if (vs_rise) m_locked = 1;
            else if (m_locked && de_i && fifo_empty) begin
                m_locked = 0;
                m_uf++;
            end
            if (vs_rise) m_y = 0;
            else if (!de_i && m_run > 0) m_y++;
            if (de_i) m_run++;
            else begin
                if (m_run > 0 && m_run != H) m_le++;
                m_run = 0;
            end
            m_prev_vs = vsycn_i;
        end
    endtask

    // ---------------- per-cycle compare ----------------
    bit          cap_en = 0, rd_watch = 0;
    int          cap_n = 0, fs_n = 0, rd_n = 0, first_dei = -1, first_deo = -1;
    logic [23:0] cap [3];

    always @(negedge clk) begin
        logic [31:0] exp_rd;
        rd_seen = fifo_rd_en;
        if (m_valid) begin
            exp_rd = 32'(de_i && !fifo_empty && m_locked);
            chk("fifo_rd_en", 32'(fifo_rd_en), exp_rd);
            chk("sat fifo_rd_en", 32'(s_rd_en), exp_rd);
            chk("frame_start", 32'(frame_start), 32'(m_fs));
            chk("vsycn_o", 32'(vsycn_o), 32'(pipe1.vs));
            chk("hsync_o", 32'(hsync_o), 32'(pipe1.hs));
            chk("de_o", 32'(de_o), 32'(pipe1.de));
            chk("rgb_o", 32'(rgb_o), 32'(pipe1.rgb));
            chk("locked", 32'(locked), 32'(m_locked));
            chk("underflow_cnt", 32'(underflow_cnt), 32'(sat(m_uf, 65535)));
            chk("line_err_cnt", 32'(line_err_cnt), 32'(sat(m_le, 65535)));
            chk("sat underflow_cnt", 32'(s_uf_cnt), 32'(sat(m_uf, 3)));
            chk("sat line_err_cnt", 32'(s_le_cnt), 32'(sat(m_le, 3)));
            chk("line_cnt", 32'(line_cnt), 32'(sat(m_y, (1 << Y_W) - 1)));
        end
        if (cap_en && de_o && cap_n < 3) begin
            cap[cap_n] = rgb_o;
            cap_n++;
        end
        if (cap_en && de_o && first_deo < 0) first_deo = cyc;
        if (cap_en && frame_start) fs_n++;
        if (rd_watch && fifo_rd_en) rd_n++;
    end

    // ---------------- stimulus ----------------
    logic [15:0] preload [3] = '{16'hF800, 16'h07E0, 16'h001F};
    int          pre_idx = 3;
    int          line_len [V] = '{H, H, H, H};

    function automatic logic [15:0] next_word();
        if (pre_idx < 3) begin
            pre_idx++;
            return preload[pre_idx-1];
        end
        return 16'($urandom);
    endfunction

    task automatic drive(input bit vs, input bit hs, input bit de,
                         input bit rst = 1'b1, input bit frc = 1'b0);
        @(posedge clk);
        model_step();
        #1;
        while (q.size() < 4) q.push_back(next_word());
        rest_n     = rst;
        vsycn_i    = vs;
        hsync_i    = hs;
        de_i       = de;
        fifo_empty = frc || (q.size() == 0);
        if (cap_en && de && first_dei < 0) first_dei = cyc;
    endtask

    task automatic do_line(input int len, input int uf_px, input int rst_px);
        drive(0, 1, 0); drive(0, 1, 0); drive(0, 0, 0); drive(0, 0, 0);
        for (int p = 0; p < len; p++) drive(0, 0, 1, p != rst_px, p == uf_px);
        drive(0, 0, 0); drive(0, 0, 0);
    endtask

    task automatic do_frame(input int uf_line = -1, input int uf_px = -1,
                            input int rst_line = -1, input int rst_px = -1);
        drive(1, 0, 0); drive(1, 0, 0); drive(0, 0, 0);
        for (int l = 0; l < V; l++)
            do_line(line_len[l], (l == uf_line) ? uf_px : -1, (l == rst_line) ? rst_px : -1);
    endtask

    initial begin
        // reset values
        drive(0, 0, 0, 0); drive(0, 0, 0, 0); drive(0, 0, 0, 0);
        drive(0, 0, 0, 1);
        chk("reset de_o", 32'(de_o), 0);
        chk("reset rgb_o", 32'(rgb_o), 0);
        chk("reset frame_start", 32'(frame_start), 0);
        chk("reset locked", 32'(locked), 0);
        chk("reset underflow_cnt", 32'(underflow_cnt), 0);
        chk("reset line_err_cnt", 32'(line_err_cnt), 0);

        // first frame with preloaded primaries
        q.delete();
        pre_idx = 0;
        cap_en = 1;
        do_frame();
        drive(0, 0, 0); drive(0, 0, 0);
        cap_en = 0;
        chk("first pixel red", 32'(cap[0]), 32'h00FF0000);
        chk("second pixel green", 32'(cap[1]), 32'h0000FF00);
        chk("third pixel blue", 32'(cap[2]), 32'h000000FF);
        chk("frame_start pulses", 32'(fs_n), 1);
        chk("de_o lag", 32'(first_deo - first_dei), 2);
        chk("lines in frame", 32'(line_cnt), 4);

        // FIFO empty at pixel 3 of line 2
        do_frame(1, 2);
        chk("underflow once", 32'(underflow_cnt), 1);
        chk("unlocked after underflow", 32'(locked), 0);
        do_frame();
        chk("relocked", 32'(locked), 1);

        // short and long lines
        line_len = '{H, H - 1, H + 1, H};
        do_frame();
        line_len = '{H, H, H, H};
        chk("line errors", 32'(line_err_cnt), 2);
        chk("underflow unchanged", 32'(underflow_cnt), 1);

        // saturation of the narrow counter
        for (int f = 0; f < 5; f++) do_frame(0, 1);
        chk("underflow wide", 32'(underflow_cnt), 6);
        chk("underflow saturated", 32'(s_uf_cnt), 3);

        // reset for one cycle during an active line
        drive(1, 0, 0); drive(1, 0, 0); drive(0, 0, 0);
        do_line(H, -1, -1);
        drive(0, 1, 0); drive(0, 1, 0); drive(0, 0, 0); drive(0, 0, 0);
        for (int p = 0; p < H; p++) begin
            drive(0, 0, 1, p != 3);
            if (p == 4) begin
                chk("post-reset de_o", 32'(de_o), 0);
                chk("post-reset rgb_o", 32'(rgb_o), 0);
                chk("post-reset locked", 32'(locked), 0);
                chk("post-reset fifo_rd_en", 32'(fifo_rd_en), 0);
                chk("post-reset underflow_cnt", 32'(underflow_cnt), 0);
                chk("post-reset line_err_cnt", 32'(line_err_cnt), 0);
            end
        end
        drive(0, 0, 0); drive(0, 0, 0);
        rd_watch = 1;
        rd_n = 0;
        do_line(H, -1, -1);
        do_line(H, -1, -1);
        rd_watch = 0;
        chk("no reads before vsync", 32'(rd_n), 0);
        do_frame();
        chk("locked after new frame", 32'(locked), 1);

        // randomized frames
        for (int f = 0; f < 20; f++) begin
            int ul, up, rl, rp;
            for (int l = 0; l < V; l++)
                line_len[l] = ($urandom_range(0, 3) == 0) ? (H - 1 + int'($urandom_range(0, 2))) : H;
            ul = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, V - 1)) : -1;
            up = int'($urandom_range(0, H - 2));
            rl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, V - 1)) : -1;
            rp = int'($urandom_range(0, H - 2));
            do_frame(ul, up, rl, rp);
        end
        line_len = '{H, H, H, H};

        // unstructured random timing, including vsync rising during de
        for (int c = 0; c < 400; c++)
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 49) != 0,
                  $urandom_range(0, 9) == 0);
        drive(0, 0, 0); drive(0, 0, 0); drive(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
